// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU types, VRAM/OAM map constants and address decode helpers
package ppu_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } PPU_STATES_t;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_SETUP,
        DMA_RD,
        DMA_WR
    } dma_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_PPU,
        OWN_DMA
    } owner_t;

    localparam logic [15:0] VRAM_BASE = 16'h8000;
    localparam logic [15:0] VRAM_END  = 16'h9FFF;
    localparam logic [15:0] OAM_BASE  = 16'hFE00;
    localparam logic [15:0] OAM_END   = 16'hFE9F;

    function automatic logic in_vram(input logic [15:0] addr);
        return (addr >= VRAM_BASE) && (addr <= VRAM_END);
    endfunction

    function automatic logic in_oam(input logic [15:0] addr);
        return (addr >= OAM_BASE) && (addr <= OAM_END);
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// rtl/oam_dma_engine.sv - FF46 OAM DMA sequencer: setup wait, source read, OAM write per byte
import ppu_pkg::*;

module oam_dma_engine #(
    parameter int LEN          = 160,
    parameter int SETUP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  src_page,
    output logic [15:0] src_addr,
    output logic        src_rd,
    input  logic [7:0]  src_data,
    output logic        active,
    output logic        wr_req,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data
);

    localparam logic [7:0] LEN_LAST   = 8'(LEN - 1);
    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);

    dma_state_t state, next_state;
    logic [7:0] idx;
    logic [7:0] page;
    logic [7:0] setup_cnt;

    // State register; reset aborts any transfer at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DMA_IDLE;
        else      state <= next_state;
    end

    // Next state: a start pulse always restarts from SETUP, even on the last write
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = DMA_SETUP;
        end else begin
            case (state)
                DMA_IDLE:  next_state = DMA_IDLE;
                DMA_SETUP: if (setup_cnt == SETUP_LAST) next_state = DMA_RD;
                DMA_RD:    next_state = DMA_WR;
                DMA_WR:    next_state = (idx == LEN_LAST) ? DMA_IDLE : DMA_RD;
                default:   next_state = DMA_IDLE;
            endcase
        end
    end

    // Page latch, setup wait counter and byte index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= 8'd0;
            page      <= 8'd0;
            setup_cnt <= 8'd0;
        end else if (start) begin
            idx       <= 8'd0;
            page      <= src_page;
            setup_cnt <= 8'd0;
        end else if (state == DMA_SETUP) begin
            setup_cnt <= setup_cnt + 8'd1;
        end else if (state == DMA_WR) begin
            idx <= (idx == LEN_LAST) ? 8'd0 : idx + 8'd1;
        end
    end

    // Outputs; a write coinciding with a restart is dropped so the old page never lands
    always_comb begin
        active   = (state != DMA_IDLE);
        src_rd   = (state == DMA_RD);
        src_addr = {page, idx};
        wr_req   = (state == DMA_WR) && !start;
        wr_addr  = OAM_BASE + {8'h00, idx};
        wr_data  = src_data;
    end

endmodule

// File: rtl/ppu_mem_arbiter.sv
// rtl/ppu_mem_arbiter.sv - VRAM/OAM port arbiter (DMA > PPU > CPU); mode lockout under PPU_ARB_LOCKOUT_EN
module ppu_mem_arbiter #(
    parameter int DMA_LEN   = 160,
    parameter int DMA_SETUP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        LCDC_EN,
    input  logic [1:0]  PPU_MODE,
    input  logic        PPU_RD,
    input  logic [15:0] PPU_ADDR,
    output logic [7:0]  PPU_DATA,
    input  logic [15:0] CPU_ADDR,
    input  logic        CPU_RD,
    input  logic        CPU_WR,
    input  logic [7:0]  CPU_WDATA,
    output logic [7:0]  CPU_RDATA,
    output logic        CPU_BLOCKED,
    input  logic        DMA_START,
    input  logic [7:0]  DMA_SRC,
    output logic [15:0] DMA_SRC_ADDR,
    output logic        DMA_SRC_RD,
    input  logic [7:0]  DMA_SRC_DATA,
    output logic        DMA_ACTIVE,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_RD,
    output logic        MEM_WR,
    output logic [7:0]  MEM_WDATA,
    input  logic [7:0]  MEM_RDATA
);
    import ppu_pkg::*;

    logic        dma_wr_req;
    logic [15:0] dma_wr_addr;
    logic [7:0]  dma_wr_data;
    logic        cpu_oam, cpu_hit, cpu_rd, cpu_wr, cpu_grant, ppu_grant, lockout;
    owner_t      owner_d, owner_q;
    logic        cpu_miss_q, ppu_miss_q;
    logic [7:0]  cpu_hold, ppu_hold;

    oam_dma_engine #(
        .LEN          (DMA_LEN),
        .SETUP_CYCLES (DMA_SETUP)
    ) u_dma (
        .clk      (clk),
        .rst      (rst),
        .start    (DMA_START),
        .src_page (DMA_SRC),
        .src_addr (DMA_SRC_ADDR),
        .src_rd   (DMA_SRC_RD),
        .src_data (DMA_SRC_DATA),
        .active   (DMA_ACTIVE),
        .wr_req   (dma_wr_req),
        .wr_addr  (dma_wr_addr),
        .wr_data  (dma_wr_data)
    );

    assign cpu_oam = in_oam(CPU_ADDR);
    assign cpu_hit = in_vram(CPU_ADDR) || cpu_oam;
    assign cpu_wr  = CPU_WR && cpu_hit;
    assign cpu_rd  = CPU_RD && !CPU_WR && cpu_hit;

`ifdef PPU_ARB_LOCKOUT_EN
    PPU_STATES_t mode;
    assign mode    = PPU_STATES_t'(PPU_MODE);
    assign lockout = (LCDC_EN && cpu_oam && (mode == SCAN || mode == DRAW))
                  || (LCDC_EN && in_vram(CPU_ADDR) && mode == DRAW)
                  || (cpu_oam && DMA_ACTIVE);
`else
    logic unused_mode;
    assign unused_mode = ^{LCDC_EN, PPU_MODE};
    assign lockout     = 1'b0;
`endif

    assign ppu_grant   = PPU_RD && !dma_wr_req;
    assign CPU_BLOCKED = (cpu_rd || cpu_wr) && (lockout || PPU_RD || dma_wr_req);
    assign cpu_grant   = (cpu_rd || cpu_wr) && !CPU_BLOCKED;

    // Port mux in priority order; strobes are held off while reset is asserted
    always_comb begin
        MEM_ADDR  = 16'h0000;
        MEM_RD    = 1'b0;
        MEM_WR    = 1'b0;
        MEM_WDATA = 8'h00;
        owner_d   = OWN_NONE;
        if (dma_wr_req) begin
            MEM_ADDR  = dma_wr_addr;
            MEM_WR    = rst;
            MEM_WDATA = dma_wr_data;
            owner_d   = OWN_DMA;
        end else if (ppu_grant) begin
            MEM_ADDR = PPU_ADDR;
            MEM_RD   = rst;
            owner_d  = OWN_PPU;
        end else if (cpu_grant) begin
            MEM_ADDR  = CPU_ADDR;
            MEM_RD    = rst && cpu_rd;
            MEM_WR    = rst && cpu_wr;
            MEM_WDATA = CPU_WDATA;
            owner_d   = cpu_rd ? OWN_CPU : OWN_NONE;
        end
    end

    // Owner tag, refused-read flags and last delivered data for each reader
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q    <= OWN_NONE;
            cpu_miss_q <= 1'b0;
            ppu_miss_q <= 1'b0;
            cpu_hold   <= 8'hFF;
            ppu_hold   <= 8'hFF;
        end else begin
            owner_q    <= owner_d;
            cpu_miss_q <= cpu_rd && CPU_BLOCKED;
            ppu_miss_q <= PPU_RD && !ppu_grant;
            cpu_hold   <= CPU_RDATA;
            ppu_hold   <= PPU_DATA;
        end
    end

    // Read steering: owner gets the macro data, a refused reader gets FF, others hold
    always_comb begin
        CPU_RDATA = (owner_q == OWN_CPU) ? MEM_RDATA : (cpu_miss_q ? 8'hFF : cpu_hold);
        PPU_DATA  = (owner_q == OWN_PPU) ? MEM_RDATA : (ppu_miss_q ? 8'hFF : ppu_hold);
    end

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// tb/tb_ppu_mem_arbiter.sv - directed self-checking bench for ppu_mem_arbiter
module tb_ppu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lcdc_en = 1'b0;
    logic [1:0]  ppu_mode = 2'd0;
    logic        ppu_rd = 1'b0;
    logic [15:0] ppu_addr = 16'h0;
    logic [7:0]  ppu_data;
    logic [15:0] cpu_addr = 16'h0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic [7:0]  cpu_rdata;
    logic        cpu_blocked;
    logic        dma_start = 1'b0;
    logic [7:0]  dma_src = 8'h0;
    logic [15:0] dma_src_addr;
    logic        dma_src_rd;
    logic [7:0]  dma_src_data = 8'h0;
    logic        dma_active;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h0;

    int checks = 0;
    int errors = 0;

    logic [15:0] wr_addr_log [0:1023];
    logic [7:0]  wr_data_log [0:1023];
    int          wr_n = 0;

    ppu_mem_arbiter dut (
        .clk(clk), .rst(rst), .LCDC_EN(lcdc_en), .PPU_MODE(ppu_mode),
        .PPU_RD(ppu_rd), .PPU_ADDR(ppu_addr), .PPU_DATA(ppu_data),
        .CPU_ADDR(cpu_addr), .CPU_RD(cpu_rd), .CPU_WR(cpu_wr),
        .CPU_WDATA(cpu_wdata), .CPU_RDATA(cpu_rdata), .CPU_BLOCKED(cpu_blocked),
        .DMA_START(dma_start), .DMA_SRC(dma_src), .DMA_SRC_ADDR(dma_src_addr),
        .DMA_SRC_RD(dma_src_rd), .DMA_SRC_DATA(dma_src_data), .DMA_ACTIVE(dma_active),
        .MEM_ADDR(mem_addr), .MEM_RD(mem_rd), .MEM_WR(mem_wr),
        .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory macro and system bus models plus a log of every port write
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_addr[7:0] ^ 8'h3C;
        if (dma_src_rd) dma_src_data <= dma_src_addr[7:0] ^ dma_src_addr[15:8];
        if (mem_wr && wr_n < 1024) begin
            wr_addr_log[wr_n] <= mem_addr;
            wr_data_log[wr_n] <= mem_wdata;
            wr_n <= wr_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ppu_rd = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; dma_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'h8000;
        tick(); tick(); #1;
        checks++; if (ppu_data !== 8'hFF) begin errors++; $display("FAIL reset_ppu_data: got %h expected FF", ppu_data); end
        checks++; if (cpu_rdata !== 8'hFF) begin errors++; $display("FAIL reset_cpu_rdata: got %h expected FF", cpu_rdata); end
        checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL reset_dma_active: got %b expected 0", dma_active); end
        checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_strobes: got rd=%b wr=%b expected 0 0", mem_rd, mem_wr); end
        checks++; if (dma_src_rd !== 1'b0) begin errors++; $display("FAIL reset_src_rd: got %b expected 0", dma_src_rd); end
        idle(); rst = 1'b1;
        tick();
    endtask

    task automatic test_cpu_read();
        lcdc_en = 1'b1; ppu_mode = 2'd0; cpu_rd = 1'b1; cpu_addr = 16'h8012; #1;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h8012) begin errors++; $display("FAIL cpu_read_port: got rd=%b addr=%h expected 1 8012", mem_rd, mem_addr); end
        checks++; if (cpu_blocked !== 1'b0) begin errors++; $display("FAIL cpu_read_blocked: got %b expected 0", cpu_blocked); end
        tick(); idle();
        checks++; if (cpu_rdata !== 8'h2E) begin errors++; $display("FAIL cpu_read_data: got %h expected 2E", cpu_rdata); end
    endtask

    task automatic test_draw_collision();
        lcdc_en = 1'b1; ppu_mode = 2'd3;
        cpu_rd = 1'b1; cpu_addr = 16'h8000; ppu_rd = 1'b1; ppu_addr = 16'h9800; #1;
        checks++; if (mem_addr !== 16'h9800 || mem_rd !== 1'b1) begin errors++; $display("FAIL draw_port: got addr=%h rd=%b expected 9800 1", mem_addr, mem_rd); end
        checks++; if (cpu_blocked !== 1'b1) begin errors++; $display("FAIL draw_blocked: got %b expected 1", cpu_blocked); end
        tick(); idle();
        checks++; if (cpu_rdata !== 8'hFF) begin errors++; $display("FAIL draw_cpu_rdata: got %h expected FF", cpu_rdata); end
        checks++; if (ppu_data !== 8'h3C) begin errors++; $display("FAIL draw_ppu_data: got %h expected 3C", ppu_data); end
        ppu_mode = 2'd0; cpu_rd = 1'b1; cpu_addr = 16'h8001;
        tick(); idle();
        checks++; if (cpu_rdata !== 8'h3D) begin errors++; $display("FAIL hold_cpu_rdata: got %h expected 3D", cpu_rdata); end
        checks++; if (ppu_data !== 8'h3C) begin errors++; $display("FAIL hold_ppu_data: got %h expected 3C", ppu_data); end
    endtask

    task automatic test_cpu_write();
        ppu_mode = 2'd0; cpu_wr = 1'b1; cpu_addr = 16'h9800; cpu_wdata = 8'h5A; #1;
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 16'h9800 || mem_wdata !== 8'h5A) begin errors++; $display("FAIL cpu_write_port: got wr=%b addr=%h data=%h expected 1 9800 5A", mem_wr, mem_addr, mem_wdata); end
        checks++; if (cpu_blocked !== 1'b0) begin errors++; $display("FAIL cpu_write_blocked: got %b expected 0", cpu_blocked); end
        cpu_rd = 1'b1; #1;
        checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL cpu_rdwr_as_write: got wr=%b rd=%b expected 1 0", mem_wr, mem_rd); end
        tick(); idle();
    endtask

    task automatic test_lockout();
        logic       exp_blk;
        logic [7:0] exp_data;
`ifdef PPU_ARB_LOCKOUT_EN
        exp_blk = 1'b1; exp_data = 8'hFF;
`else
        exp_blk = 1'b0; exp_data = 8'h2C;
`endif
        lcdc_en = 1'b1; ppu_mode = 2'd3; cpu_rd = 1'b1; cpu_addr = 16'hFE10; #1;
        checks++; if (cpu_blocked !== exp_blk) begin errors++; $display("FAIL oam_draw_blocked: got %b expected %b", cpu_blocked, exp_blk); end
        checks++; if (mem_rd !== !exp_blk) begin errors++; $display("FAIL oam_draw_mem_rd: got %b expected %b", mem_rd, !exp_blk); end
        tick(); idle();
        checks++; if (cpu_rdata !== exp_data) begin errors++; $display("FAIL oam_draw_rdata: got %h expected %h", cpu_rdata, exp_data); end
        lcdc_en = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'h8000; #1;
        checks++; if (cpu_blocked !== 1'b0 || mem_rd !== 1'b1) begin errors++; $display("FAIL lcd_off_access: got blk=%b rd=%b expected 0 1", cpu_blocked, mem_rd); end
        lcdc_en = 1'b1; ppu_mode = 2'd2; #1;
        checks++; if (cpu_blocked !== 1'b0) begin errors++; $display("FAIL scan_vram_access: got %b expected 0", cpu_blocked); end
        tick(); idle();
    endtask

    task automatic test_dma_full();
        int mark, act, rd_i, bad_src, bad_wr, inject;
        lcdc_en = 1'b0; mark = wr_n;
        dma_src = 8'hC1; dma_start = 1'b1; tick(); dma_start = 1'b0;
        act = 0; rd_i = 0; bad_src = 0; inject = 0;
        for (int cyc = 0; cyc < 500 && dma_active; cyc++) begin
            act++;
            if (dma_src_rd) begin
                if (dma_src_addr !== {8'hC1, rd_i[7:0]}) bad_src++;
                rd_i++;
            end
            if (inject == 1) begin
                checks++; if (ppu_data !== 8'hFF) begin errors++; $display("FAIL ppu_dma_collision_data: got %h expected FF", ppu_data); end
                ppu_rd = 1'b0; inject = 2;
            end
            if (mem_wr && inject == 0) begin
                ppu_rd = 1'b1; ppu_addr = 16'hFE05; #1;
                checks++; if (mem_addr !== 16'hFE00 || mem_wr !== 1'b1) begin errors++; $display("FAIL dma_beats_ppu: got addr=%h wr=%b expected FE00 1", mem_addr, mem_wr); end
                inject = 1;
            end
            tick();
        end
        idle();
        checks++; if (act !== 321) begin errors++; $display("FAIL dma_active_len: got %0d expected 321", act); end
        checks++; if (bad_src !== 0 || rd_i !== 160) begin errors++; $display("FAIL dma_src_reads: got bad=%0d reads=%0d expected 0 160", bad_src, rd_i); end
        checks++; if (wr_n - mark !== 160) begin errors++; $display("FAIL dma_write_count: got %0d expected 160", wr_n - mark); end
        bad_wr = 0;
        for (int i = 0; i < 160; i++) begin
            if (wr_addr_log[mark + i] !== 16'hFE00 + 16'(i) || wr_data_log[mark + i] !== (8'(i) ^ 8'hC1)) bad_wr++;
        end
        checks++; if (bad_wr !== 0) begin errors++; $display("FAIL dma_write_content: got %0d bad expected 0", bad_wr); end
    endtask

    task automatic test_restart();
        int mark0, mark, act, found;
        logic [15:0] first_src;
        mark0 = wr_n;
        dma_src = 8'hC1; dma_start = 1'b1; tick(); dma_start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 400 && found == 0; cyc++) begin
            if (dma_src_rd && dma_src_addr == 16'hC132) found = 1;
            else tick();
        end
        checks++; if (found !== 1) begin errors++; $display("FAIL restart_reach_idx50: got %0d expected 1", found); end
        checks++; if (wr_n - mark0 !== 50) begin errors++; $display("FAIL restart_pre_writes: got %0d expected 50", wr_n - mark0); end
        mark = wr_n;
        dma_src = 8'hD0; dma_start = 1'b1; tick(); dma_start = 1'b0;
        act = 0; first_src = 16'hFFFF;
        for (int cyc = 0; cyc < 500 && dma_active; cyc++) begin
            act++;
            if (dma_src_rd && first_src == 16'hFFFF) first_src = dma_src_addr;
            tick();
        end
        checks++; if (first_src !== 16'hD000) begin errors++; $display("FAIL restart_first_src: got %h expected D000", first_src); end
        checks++; if (act !== 321) begin errors++; $display("FAIL restart_active_len: got %0d expected 321", act); end
        checks++; if (wr_addr_log[mark] !== 16'hFE00 || wr_n - mark !== 160) begin errors++; $display("FAIL restart_writes: got first=%h count=%0d expected FE00 160", wr_addr_log[mark], wr_n - mark); end
        checks++; if (wr_data_log[mark + 50] !== 8'hE2) begin errors++; $display("FAIL restart_fe32_data: got %h expected E2", wr_data_log[mark + 50]); end
    endtask

    task automatic test_reset_abort();
        int mark, found;
        dma_src = 8'hC1; dma_start = 1'b1; tick(); dma_start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 400 && found == 0; cyc++) begin
            if (dma_src_rd && dma_src_addr == 16'hC150) found = 1;
            else tick();
        end
        checks++; if (found !== 1) begin errors++; $display("FAIL abort_reach_idx80: got %0d expected 1", found); end
        rst = 1'b0; #1;
        checks++; if (dma_active !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL abort_immediate: got active=%b wr=%b expected 0 0", dma_active, mem_wr); end
        mark = wr_n;
        tick(); tick(); rst = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) tick();
        checks++; if (wr_n !== mark || dma_active !== 1'b0) begin errors++; $display("FAIL abort_no_writes: got writes=%0d active=%b expected 0 0", wr_n - mark, dma_active); end
        checks++; if (cpu_rdata !== 8'hFF || ppu_data !== 8'hFF) begin errors++; $display("FAIL abort_rdata: got cpu=%h ppu=%h expected FF FF", cpu_rdata, ppu_data); end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_draw_collision();
        test_cpu_write();
        test_lockout();
        test_dma_full();
        test_restart();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
